// File: rtl/cache_set_ctrl.sv
// Lookup/refill controller for one WAYS-way cache set: tag compare, victim choice,
// memory refill handshake, and whole-set flush through one-hot way write enables.
module cache_set_ctrl #(
    parameter int TAG_W = 24,
    parameter int WAYS  = 8,
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  req_ready,
    input  logic                  flush_req,
    output logic                  flush_done,
    input  logic [WAYS-1:0]       set_valid,
    input  logic [WAYS*TAG_W-1:0] set_tags,
    output logic                  wr_en,
    output logic [WAYS-1:0]       way_sel,
    output logic [TAG_W-1:0]      wr_tag,
    output logic                  wr_valid,
    output logic                  mem_req,
    output logic [TAG_W-1:0]      mem_tag,
    input  logic                  mem_ack,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [IDX_W-1:0]      resp_way
);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, FILL, RESP, FLUSH} state_t;

    state_t            state, state_nx;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  vic_q;
    logic [IDX_W-1:0]  rr_q;
    logic              resp_hit_q;
    logic [IDX_W-1:0]  resp_way_q;

    logic [WAYS-1:0]   hit_vec;
    logic              any_hit;
    logic              any_free;
    logic [IDX_W-1:0]  hit_idx;
    logic [IDX_W-1:0]  free_idx;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < WAYS; i++) begin
            hit_vec[i] = set_valid[i] && (set_tags[i*TAG_W +: TAG_W] == tag_q);
        end
    end

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        any_hit  = 1'b0;
        hit_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!set_valid[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        wr_en      = 1'b0;
        way_sel    = '0;
        wr_tag     = '0;
        wr_valid   = 1'b0;
        mem_req    = 1'b0;
        mem_tag    = '0;
        resp_valid = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (flush_req) begin
                    state_nx = FLUSH;
                end else if (req_valid) begin
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: state_nx = any_hit ? RESP : MISS;
            MISS: begin
                mem_req = 1'b1;
                mem_tag = tag_q;
                if (mem_ack) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                wr_en    = 1'b1;
                way_sel  = WAYS'(1) << vic_q;
                wr_tag   = tag_q;
                wr_valid = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            FLUSH: begin
                wr_en      = 1'b1;
                way_sel    = '1;
                flush_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tag_q      <= '0;
            vic_q      <= '0;
            rr_q       <= '0;
            resp_hit_q <= 1'b0;
            resp_way_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (!flush_req && req_valid) begin
                        tag_q <= req_tag;
                    end
                end
                LOOKUP: begin
                    if (any_hit) begin
                        resp_hit_q <= 1'b1;
                        resp_way_q <= hit_idx;
                    end else if (any_free) begin
                        vic_q <= free_idx;
                    end else begin
                        // Full set: evict round-robin; IDX_W-bit wrap is the modulo.
                        vic_q <= rr_q;
                        rr_q  <= rr_q + 1'b1;
                    end
                end
                FILL: begin
                    resp_hit_q <= 1'b0;
                    resp_way_q <= vic_q;
                end
                FLUSH: rr_q <= '0;
                default: ;
            endcase
        end
    end

    assign resp_hit = resp_hit_q;
    assign resp_way = resp_way_q;

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Bench for cache_set_ctrl: emulated set storage, transaction-level reference model
// producing per-cycle expected outputs, and a single negedge compare process.
module tb_cache_set_ctrl;

    localparam int TAG_W = 24;
    localparam int WAYS  = 8;
    localparam int IDX_W = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  req_valid = 1'b0;
    logic [TAG_W-1:0]      req_tag = '0;
    logic                  req_ready;
    logic                  flush_req = 1'b0;
    logic                  flush_done;
    logic [WAYS-1:0]       set_valid;
    logic [WAYS*TAG_W-1:0] set_tags;
    logic                  wr_en;
    logic [WAYS-1:0]       way_sel;
    logic [TAG_W-1:0]      wr_tag;
    logic                  wr_valid;
    logic                  mem_req;
    logic [TAG_W-1:0]      mem_tag;
    logic                  mem_ack = 1'b0;
    logic                  resp_valid;
    logic                  resp_hit;
    logic [IDX_W-1:0]      resp_way;

    logic                  poke_en = 1'b0;
    logic [IDX_W-1:0]      poke_way = '0;
    logic [TAG_W-1:0]      poke_tag = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic             ready;
        logic             rv;
        logic             rh;
        logic [IDX_W-1:0] rw;
        logic             we;
        logic [WAYS-1:0]  ws;
        logic [TAG_W-1:0] wt;
        logic             wv;
        logic             mr;
        logic [TAG_W-1:0] mt;
        logic             fd;
    } exp_t;

    exp_t exp_q [int];

    bit               m_valid [WAYS];
    logic [TAG_W-1:0] m_tag   [WAYS];
    int               m_rr = 0;

    logic             last_resp_hit;
    logic [IDX_W-1:0] last_resp_way;
    int               last_resp_cyc = -1;
    logic [WAYS-1:0]  last_fill_sel;
    logic             last_fill_valid;
    logic [WAYS-1:0]  last_flush_sel;
    logic             last_flush_wv;
    logic [TAG_W-1:0] last_mem_tag;
    int               mem_req_cnt = 0;

    cache_set_ctrl #(.TAG_W(TAG_W), .WAYS(WAYS), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .set_valid  (set_valid),
        .set_tags   (set_tags),
        .wr_en      (wr_en),
        .way_sel    (way_sel),
        .wr_tag     (wr_tag),
        .wr_valid   (wr_valid),
        .mem_req    (mem_req),
        .mem_tag    (mem_tag),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Set storage: written by the DUT's way enables, or poked directly by the bench.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            set_valid <= '0;
            set_tags  <= '0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (way_sel[i]) begin
                        set_valid[i]                <= wr_valid;
                        set_tags[i*TAG_W +: TAG_W]  <= wr_tag;
                    end
                end
            end
            if (poke_en) begin
                set_valid[poke_way]                     <= 1'b1;
                set_tags[int'(poke_way)*TAG_W +: TAG_W] <= poke_tag;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t r;
        r = '0;
        r.ready = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin : cmp
        exp_t e;
        if (!reset) begin
            e = exp_q.exists(cyc) ? exp_q[cyc] : idle_rec();
            chk("req_ready",  32'(req_ready),  32'(e.ready));
            chk("resp_valid", 32'(resp_valid), 32'(e.rv));
            chk("wr_en",      32'(wr_en),      32'(e.we));
            chk("way_sel",    32'(way_sel),    32'(e.ws));
            chk("mem_req",    32'(mem_req),    32'(e.mr));
            chk("flush_done", 32'(flush_done), 32'(e.fd));
            if (e.rv) begin
                chk("resp_hit", 32'(resp_hit), 32'(e.rh));
                chk("resp_way", 32'(resp_way), 32'(e.rw));
            end
            if (e.we) begin
                chk("wr_tag",   32'(wr_tag),   32'(e.wt));
                chk("wr_valid", 32'(wr_valid), 32'(e.wv));
            end
            if (e.mr) chk("mem_tag", 32'(mem_tag), 32'(e.mt));
            if (resp_valid) begin
                last_resp_hit = resp_hit;
                last_resp_way = resp_way;
                last_resp_cyc = cyc;
            end
            if (wr_en && !flush_done) begin
                last_fill_sel   = way_sel;
                last_fill_valid = wr_valid;
            end
            if (flush_done) begin
                last_flush_sel = way_sel;
                last_flush_wv  = wr_valid;
            end
            if (mem_req) begin
                last_mem_tag = mem_tag;
                mem_req_cnt++;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: decide hit/victim from the modelled set and lay out expected cycles.
    task automatic plan_txn(input int a, input logic [TAG_W-1:0] tag, input int d,
                            output int ack_cyc, output int end_cyc);
        exp_t r;
        int   way;
        bit   hit;
        bit   found;
        hit = 0;
        found = 0;
        way = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (!hit && m_valid[i] && m_tag[i] == tag) begin
                hit = 1;
                way = i;
            end
        end
        r = '0;
        exp_q[a+1] = r;
        if (hit) begin
            r.rv = 1'b1;
            r.rh = 1'b1;
            r.rw = IDX_W'(way);
            exp_q[a+2] = r;
            ack_cyc = -1;
            end_cyc = a + 3;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (!found && !m_valid[i]) begin
                    found = 1;
                    way = i;
                end
            end
            if (!found) begin
                way  = m_rr;
                m_rr = (m_rr + 1) % WAYS;
            end
            ack_cyc = a + 2 + d;
            for (int c = a + 2; c <= ack_cyc; c++) begin
                r = '0;
                r.mr = 1'b1;
                r.mt = tag;
                exp_q[c] = r;
            end
            r = '0;
            r.we = 1'b1;
            r.ws = WAYS'(1) << way;
            r.wt = tag;
            r.wv = 1'b1;
            exp_q[ack_cyc+1] = r;
            r = '0;
            r.rv = 1'b1;
            r.rw = IDX_W'(way);
            exp_q[ack_cyc+2] = r;
            end_cyc = ack_cyc + 3;
            m_valid[way] = 1;
            m_tag[way]   = tag;
        end
    endtask

    task automatic plan_flush(input int a);
        exp_t r;
        r = '0;
        r.we = 1'b1;
        r.ws = '1;
        r.fd = 1'b1;
        exp_q[a+1] = r;
        for (int i = 0; i < WAYS; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = '0;
        end
        m_rr = 0;
    endtask

    task automatic finish_txn(input int ack_cyc, input int end_cyc);
        if (ack_cyc >= 0) begin
            wait_until(ack_cyc);
            mem_ack = 1'b1;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        wait_until(end_cyc);
    endtask

    task automatic do_req(input logic [TAG_W-1:0] tag, input int d, output int a);
        int ack_cyc, end_cyc;
        @(posedge clk);
        #1;
        a = cyc;
        req_valid = 1'b1;
        req_tag   = tag;
        plan_txn(a, tag, d, ack_cyc, end_cyc);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        finish_txn(ack_cyc, end_cyc);
    endtask

    task automatic do_flush();
        int a;
        @(posedge clk);
        #1;
        a = cyc;
        flush_req = 1'b1;
        plan_flush(a);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        wait_until(a + 3);
    endtask

    task automatic flush_with_req(input logic [TAG_W-1:0] tag, input int d, output int a);
        int ack_cyc, end_cyc;
        @(posedge clk);
        #1;
        a = cyc;
        flush_req = 1'b1;
        req_valid = 1'b1;
        req_tag   = tag;
        plan_flush(a);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        plan_txn(a + 2, tag, d, ack_cyc, end_cyc);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        finish_txn(ack_cyc, end_cyc);
    endtask

    task automatic poke(input int way, input logic [TAG_W-1:0] tag);
        @(posedge clk);
        #1;
        poke_en  = 1'b1;
        poke_way = IDX_W'(way);
        poke_tag = tag;
        m_valid[way] = 1;
        m_tag[way]   = tag;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    initial begin : stim
        int   a;
        int   cnt0;
        exp_t r;
        for (int i = 0; i < WAYS; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = '0;
        end

        #1 reset = 1'b1;
        #2;
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_wr_en",      32'(wr_en),      32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_way",   32'(resp_way),   32'd0);
        chk("rst_way_sel",    32'(way_sel),    32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_until(cyc + 3);

        // Reset in the middle of a refill wait.
        @(posedge clk);
        #1;
        a = cyc;
        req_valid = 1'b1;
        req_tag   = 24'h000077;
        r = '0;
        exp_q[a+1] = r;
        r.mr = 1'b1;
        r.mt = 24'h000077;
        exp_q[a+2] = r;
        exp_q[a+3] = r;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_until(a + 3);
        #1 reset = 1'b1;
        #1;
        chk("midmiss_mem_req",   32'(mem_req),   32'd0);
        chk("midmiss_wr_en",     32'(wr_en),     32'd0);
        chk("midmiss_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        wait_until(a + 8);

        // Cold miss, ack three cycles after mem_req rises.
        do_req(24'h00ABCD, 3, a);
        chk("cold_mem_tag",    32'(last_mem_tag),    32'h00ABCD);
        chk("cold_way_sel",    32'(last_fill_sel),   32'h01);
        chk("cold_wr_valid",   32'(last_fill_valid), 32'd1);
        chk("cold_resp_hit",   32'(last_resp_hit),   32'd0);
        chk("cold_resp_way",   32'(last_resp_way),   32'd0);
        chk("cold_latency",    32'(last_resp_cyc - a), 32'd7);

        // Repeat lookup hits way 0 with no refill.
        cnt0 = mem_req_cnt;
        do_req(24'h00ABCD, 0, a);
        chk("hit_latency",  32'(last_resp_cyc - a), 32'd2);
        chk("hit_resp_hit", 32'(last_resp_hit),     32'd1);
        chk("hit_resp_way", 32'(last_resp_way),     32'd0);
        chk("hit_no_memreq", 32'(mem_req_cnt - cnt0), 32'd0);

        // Fill the whole set, then exercise round-robin eviction.
        do_flush();
        chk("flush_way_sel",  32'(last_flush_sel), 32'hFF);
        chk("flush_wr_valid", 32'(last_flush_wv),  32'd0);
        for (int i = 0; i < WAYS; i++) begin
            do_req(TAG_W'(32'h10 + i), i % 3, a);
            if (i == 0) chk("miss_min_latency", 32'(last_resp_cyc - a), 32'd4);
        end
        chk("fill7_way_sel", 32'(last_fill_sel), 32'h80);
        do_req(24'h000020, 1, a);
        chk("evict1_way_sel", 32'(last_fill_sel), 32'h01);
        do_req(24'h000021, 2, a);
        chk("evict2_way_sel", 32'(last_fill_sel), 32'h02);
        do_req(24'h000010, 0, a);
        chk("evicted_tag_misses", 32'(last_resp_hit), 32'd0);
        chk("evict3_way_sel",     32'(last_fill_sel), 32'h04);
        do_req(24'h000020, 0, a);
        chk("new_tag_hit",     32'(last_resp_hit), 32'd1);
        chk("new_tag_hit_way", 32'(last_resp_way), 32'd0);

        // Flush and request in the same cycle: flush first, request next.
        flush_with_req(24'h000033, 1, a);
        chk("fr_flush_way_sel", 32'(last_flush_sel), 32'hFF);
        chk("fr_flush_wv",      32'(last_flush_wv),  32'd0);
        chk("fr_resp_hit",      32'(last_resp_hit),  32'd0);
        chk("fr_resp_way",      32'(last_resp_way),  32'd0);
        chk("fr_fill_sel",      32'(last_fill_sel),  32'h01);
        chk("fr_latency",       32'(last_resp_cyc - a), 32'd7);

        // Duplicate valid tag in two ways resolves to the lower index.
        poke(3, 24'h000055);
        poke(6, 24'h000055);
        do_req(24'h000055, 0, a);
        chk("dup_resp_hit", 32'(last_resp_hit), 32'd1);
        chk("dup_resp_way", 32'(last_resp_way), 32'd3);

        wait_until(cyc + 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_set_ctrl.md
# cache_set_ctrl

Lookup and refill controller for one 8-way cache set built from per-way valid bits and 24-bit tag registers. It accepts one tag lookup at a time and compares it against all stored tags and valid bits. On a miss it picks a victim way, runs a refill handshake with the next memory level, then writes the new tag and valid bit back into the set through one-hot way write enables. A flush command invalidates the whole set in one cycle.

## Interface
- TAG_W, 24, tag width
- WAYS, 8, number of ways; power of two, 2..8
- IDX_W, 3, log2(WAYS)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  lookup request
- req_tag  in  TAG_W  tag to look up
- req_ready  out  1  controller can accept a request
- flush_req  in  1  invalidate all ways
- flush_done  out  1  one-cycle pulse, flush written
- set_valid  in  WAYS  current valid bits from the set
- set_tags  in  WAYS*TAG_W  current tags; way i is at [i*TAG_W +: TAG_W]
- wr_en  out  1  write strobe to set storage
- way_sel  out  WAYS  one-hot (flush: all-ones) per-way write enable
- wr_tag  out  TAG_W  tag written to the selected way(s)
- wr_valid  out  1  valid value written to the selected way(s)
- mem_req  out  1  refill request, held until acknowledged
- mem_tag  out  TAG_W  tag being refilled
- mem_ack  in  1  refill complete
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  1 = hit, 0 = miss that has been refilled
- resp_way  out  IDX_W  way that hit or was filled

## Operation
- Reset value of every output is 0, except req_ready, which is 1.
- Internal state:
  - FSM state is reset to IDLE.
  - Captured tag tag_q is reset to 0.
  - Victim register vic_q is reset to 0.
  - Round-robin pointer rr_q (IDX_W bits) is reset to 0.
- The FSM has states IDLE, LOOKUP, MISS, FILL, RESP, FLUSH.
- IDLE:
  - req_ready=1.
  - If flush_req=1, go to FLUSH. Flush takes priority; req_valid is not accepted in that cycle.
  - Else if req_valid=1, capture req_tag into tag_q and go to LOOKUP.
- LOOKUP:
  - Way i hits when set_valid[i]=1 and its tag equals tag_q.
  - On any hit, resp_way is set to the lowest-index hitting way, resp_hit=1, and the FSM goes to RESP.
  - On a miss, the victim is the lowest-index way with set_valid=0. If all ways are valid, the victim is rr_q and rr_q increments modulo WAYS. The victim is latched into vic_q and the FSM goes to MISS.
- MISS:
  - mem_req=1 and mem_tag=tag_q.
  - Stays in MISS until mem_ack=1, then goes to FILL.
- FILL, one cycle:
  - wr_en=1, way_sel=one-hot(vic_q), wr_tag=tag_q, wr_valid=1.
  - resp_way=vic_q, resp_hit=0.
  - Goes to RESP.
- RESP, one cycle: resp_valid=1, then go to IDLE.
- FLUSH, one cycle:
  - wr_en=1, way_sel=all ones, wr_valid=0, wr_tag=0.
  - flush_done=1.
  - rr_q is reset to 0.
  - Goes to IDLE.
- wr_en, way_sel, mem_req and flush_done are 0 in every state not listed above.
- mem_ack is ignored outside MISS.
- flush_req is ignored outside IDLE. The requester holds it until flush_done.
- Reset asserted mid-operation:
  - Returns immediately to IDLE.
  - Drops mem_req.
  - Suppresses any pending write or response.
  - The set storage itself is reset by its own reset.

## Timing
- A request is accepted on the edge where req_valid=1 and req_ready=1. Call that edge cycle 0.
- Hit: LOOKUP in cycle 1, RESP in cycle 2. resp_valid is high during cycle 2.
- Miss:
  - mem_req rises in cycle 2.
  - If mem_ack is seen in cycle k (k≥2), FILL happens in cycle k+1 and resp_valid in cycle k+2.
  - With mem_ack in the same cycle mem_req rises, miss latency is 4 cycles.
- The set write made in FILL is visible on set_valid/set_tags from the next cycle, so a following request observes it.
- req_ready is low from cycle 1 until the cycle after RESP. Back-to-back requests are therefore at most one every 3 cycles on hits.
- Flush: accepted in cycle 0, FLUSH with flush_done in cycle 1, req_ready=1 again in cycle 2.
- The compare is combinational from set_valid/set_tags during LOOKUP. Both are registered storage outputs; no extra pipelining.

## Test plan
- Reset, then hold idle:
  - All outputs 0, req_ready=1.
  - Assert reset mid-MISS: mem_req drops asynchronously and no wr_en follows.
- Cold miss, tag 0x00ABCD with all ways invalid:
  - mem_req with mem_tag=0x00ABCD.
  - mem_ack after 3 cycles gives FILL with way_sel=0x01, wr_valid=1.
  - Response resp_hit=0, resp_way=0.
- Repeat tag 0x00ABCD: resp_valid exactly 2 cycles after acceptance, resp_hit=1, resp_way=0, no mem_req.
- Fill ways 0..7 with tags 0x10..0x17, then miss on 0x20 and 0x21:
  - First evicts way 0 (way_sel=0x01); second evicts way 1 (way_sel=0x02).
  - Then lookup of 0x10 misses and lookup of 0x20 hits way 0.
- Flush and request both asserted in IDLE:
  - FLUSH wins: wr_en=1, way_sel=0xFF, wr_valid=0, flush_done pulse.
  - The request is accepted on the following cycle and misses, victim way 0.
- Duplicate valid tag 0x55 forced into ways 3 and 6: lookup gives resp_way=3, resp_hit=1.
